multicast_router: RTL and testbench
===================================

Name: multicast_router

Overview:
- Parametrised multicast stage between the global buffer bus and a row of NUM_COL PEs.
- Generalises the current caster: per-column programmable ID registers, per-column one-entry output buffers, and a ready/valid handshake on every port.
- An input word carrying a TAG is delivered to every column whose ID equals the TAG.
- Words that match no column are dropped and counted.

Parameters:
DATA_WIDTH, 16, payload width (use 2*16 when routing psums)
NUM_COL, 4, number of destination columns
ID_WIDTH, 4, width of TAG and column ID registers
DROP_CNT_WIDTH, 8, width of saturating dropped-word counter

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
cfg_we  in  1  write enable for a column ID register
cfg_col  in  $clog2(NUM_COL)  column selected for the ID write
cfg_id  in  ID_WIDTH  new ID value
in_valid  in  1  input word valid
in_ready  out  1  router can accept the input word
in_tag  in  ID_WIDTH  destination tag
in_data  in  DATA_WIDTH  payload
out_valid  out  NUM_COL  per-column buffer occupied
out_ready  in  NUM_COL  per-column PE ready
out_data  out  NUM_COL*DATA_WIDTH  per-column payload; column i at bits [i*DATA_WIDTH +: DATA_WIDTH]
drop_cnt  out  DROP_CNT_WIDTH  count of words that matched no column

Behaviour:
Reset:
- rst asserted: all out_valid=0, out_data=0, drop_cnt=0, ID[i]=i (zero-extended to ID_WIDTH).
- Takes effect immediately regardless of clk.
- Reset mid-operation discards all buffered words; no partial delivery survives.
Match vector:
- match[i] = (ID[i] == in_tag), computed combinationally from the current (pre-write) ID registers.
Column free:
- free[i] = !out_valid[i] || out_ready[i].
- A buffer drained in the same cycle counts as free.
in_ready:
- in_ready = AND over i of (!match[i] || free[i]); combinational from match and out_ready.
- Zero-match: in_ready=1.
Accept:
- Occurs when in_valid && in_ready at a rising edge (edge N).
- For every matched column: out_valid[i]=1 and out_data[i]=in_data from edge N.
- Latency one cycle; data visible in the cycle after edge N.
- Delivery is atomic: all matched columns load on the same edge, or none do.
Drain:
- out_valid[i] && out_ready[i] at an edge with no new load for column i: out_valid[i] clears.
- Simultaneous drain and load: out_valid[i] stays 1 and out_data[i] takes the new word.
- Full throughput, 1 word/cycle per column.
Hold:
- While out_valid[i]=1 and out_ready[i]=0, out_data[i] is stable.
- Unmatched columns are never disturbed.
Drop:
- An accepted word with zero matches increments drop_cnt.
- drop_cnt saturates at all-ones; it does not wrap.
Config:
- cfg_we at edge N: ID[cfg_col]=cfg_id after edge N.
- A word accepted on the same edge matches against the old ID.
- Writes never affect buffered data.
- cfg_col >= NUM_COL: the write is ignored.
- Duplicate IDs are legal; the word is delivered to every column holding that ID.
Stall:
- in_ready=0 while any matched column is full and not draining.
- in_data/in_tag must be held by the source while in_valid=1 and in_ready=0.
- in_ready may depend on out_ready; there is no combinational path from in_valid to in_ready.

Optional Feature:
Macro MULTICAST_ROUTER_BCAST_EN.
- Defined: in_tag equal to all-ones (2^ID_WIDTH-1) forces match[i]=1 for all columns (broadcast), regardless of ID contents. A broadcast word is never dropped.
- Undefined: the all-ones tag is an ordinary tag compared against the ID registers.

Test Plan:
- Reset defaults: after reset, send tag=2, data=0xABCD with all out_ready=1 -> only out_valid[2]=1 one cycle later, out_data[2]=0xABCD, drop_cnt=0.
- Multicast + backpressure:
  - program ID[0]=ID[3]=5, hold out_ready[3]=0, send tag=5 data=0x1111 -> both columns load.
  - second tag=5 word sees in_ready=0 until out_ready[3]=1.
  - out_data[3] stays 0x1111 while stalled.
- Drop counting: send 300 words with tag=9 (no match) -> in_ready=1 every cycle, all out_valid=0, drop_cnt saturates at 255.
- Same-edge config race: cfg_we cfg_col=1 cfg_id=7 and accepted tag=1 on the same edge -> column 1 receives the word; the next tag=1 word is dropped, and a tag=7 word goes to column 1.
- Back-to-back throughput: 16 consecutive tag=0 words 0..15 with out_ready[0]=1 -> in_ready stays 1, column 0 outputs 0..15 on consecutive cycles.
- Async reset mid-operation: assert rst between edges with out_valid=4'b1011 -> out_valid=0 and drop_cnt=0 immediately; IDs restored to 0..3.
- MULTICAST_ROUTER_BCAST_EN (when defined): tag=4'hF, data=0x5A5A -> all four columns load 0x5A5A; drop_cnt unchanged.

Source files
------------

// File: rtl/multicast_router.sv
// Tag-matched multicast stage: delivers each input word to every column whose ID equals the tag.
// Optional broadcast on the all-ones tag is enabled with `define MULTICAST_ROUTER_BCAST_EN.
module multicast_router #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_COL        = 4,
    parameter int ID_WIDTH       = 4,
    parameter int DROP_CNT_WIDTH = 8,
    localparam int COL_W         = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [COL_W-1:0]               cfg_col,
    input  logic [ID_WIDTH-1:0]            cfg_id,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ID_WIDTH-1:0]            in_tag,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic [NUM_COL-1:0]             out_valid,
    input  logic [NUM_COL-1:0]             out_ready,
    output logic [NUM_COL*DATA_WIDTH-1:0]  out_data,
    output logic [DROP_CNT_WIDTH-1:0]      drop_cnt
);

    logic [ID_WIDTH-1:0] col_id [NUM_COL];
    logic [NUM_COL-1:0]  match;
    logic [NUM_COL-1:0]  free;
    logic [NUM_COL-1:0]  load;
    logic                accept;
    logic                no_match;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_COL; i++) begin
            match[i] = (col_id[i] == in_tag);
        end
`ifdef MULTICAST_ROUTER_BCAST_EN
        if (in_tag == '1) begin
            match = '1;
        end
`endif
    end

    // A column draining on this edge can take a new word on the same edge.
    assign free     = ~out_valid | out_ready;
    assign in_ready = &(~match | free);
    assign accept   = in_valid && in_ready;
    assign load     = accept ? match : '0;
    assign no_match = ~|match;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the ID registers are a small register file, not RAM, so resetting them to their column index is cheap and required.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COL; i++) begin
                col_id[i] <= ID_WIDTH'(i);
            end
            out_valid <= '0;
            out_data  <= '0;
            drop_cnt  <= '0;
        end else begin
            // Matching above used the old ID, so a same-edge write only affects later words.
            if (cfg_we && (32'(cfg_col) < NUM_COL)) begin
                col_id[cfg_col] <= cfg_id;
            end
            for (int i = 0; i < NUM_COL; i++) begin
                if (load[i]) begin
                    out_valid[i]                       <= 1'b1;
                    out_data[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (accept && no_match && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicast_router.sv
// Directed self-checking bench for multicast_router with the default 4-column, 16-bit configuration.
module tb_multicast_router;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int IW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_col;
    logic [IW-1:0] cfg_id;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_tag;
    logic [DW-1:0] in_data;
    logic [NC-1:0] out_valid;
    logic [NC-1:0] out_ready;
    logic [NC*DW-1:0] out_data;
    logic [CW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    multicast_router #(
        .DATA_WIDTH(DW), .NUM_COL(NC), .ID_WIDTH(IW), .DROP_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_col(cfg_col), .cfg_id(cfg_id),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] col_data(input int i);
        return out_data[i*DW +: DW];
    endfunction

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_id(input logic [1:0] col, input logic [IW-1:0] id);
        cfg_we = 1'b1; cfg_col = col; cfg_id = id;
        tick();
        cfg_we = 1'b0;
    endtask

    int rdy_errs;
    int vld_errs;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_col = '0; cfg_id = '0;
        in_valid = 1'b0; in_tag = '0; in_data = '0; out_ready = 4'hF;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data",  out_data, 64'h0);
        check("rst_drop_cnt",  64'(drop_cnt), 64'h0);

        // Default IDs: tag 2 reaches column 2 only.
        in_valid = 1'b1; in_tag = 4'd2; in_data = 16'hABCD;
        #1 check("def_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("def_out_valid", 64'(out_valid), 64'b0100);
        check("def_out_data2", 64'(col_data(2)), 64'hABCD);
        check("def_drop_cnt",  64'(drop_cnt), 64'h0);
        tick();
        check("def_drained", 64'(out_valid), 64'h0);

        // Multicast with column 3 back-pressured.
        write_id(2'd0, 4'd5);
        write_id(2'd3, 4'd5);
        out_ready = 4'b0111;
        in_valid = 1'b1; in_tag = 4'd5; in_data = 16'h1111;
        #1 check("mc_in_ready0", 64'(in_ready), 64'h1);
        tick();
        check("mc_out_valid", 64'(out_valid), 64'b1001);
        check("mc_data0", 64'(col_data(0)), 64'h1111);
        check("mc_data3", 64'(col_data(3)), 64'h1111);
        in_data = 16'h2222;
        #1 check("mc_stall_rdy", 64'(in_ready), 64'h0);
        tick();
        check("mc_stall_valid", 64'(out_valid), 64'b1000);
        check("mc_hold_data3", 64'(col_data(3)), 64'h1111);
        check("mc_stall_rdy2", 64'(in_ready), 64'h0);
        out_ready = 4'hF;
        #1 check("mc_release_rdy", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("mc2_out_valid", 64'(out_valid), 64'b1001);
        check("mc2_data0", 64'(col_data(0)), 64'h2222);
        check("mc2_data3", 64'(col_data(3)), 64'h2222);
        tick();
        check("mc2_drained", 64'(out_valid), 64'h0);

        // 300 unmatched words: always accepted, never delivered, counter saturates.
        rdy_errs = 0; vld_errs = 0;
        in_valid = 1'b1; in_tag = 4'd9;
        for (int i = 0; i < 300; i++) begin
            in_data = 16'(i);
            #1;
            if (in_ready !== 1'b1) rdy_errs++;
            tick();
            if (out_valid !== 4'b0000) vld_errs++;
            if (i == 9) check("drop_cnt_10", 64'(drop_cnt), 64'd10);
        end
        in_valid = 1'b0;
        check("drop_rdy_errs", 64'(rdy_errs), 64'h0);
        check("drop_vld_errs", 64'(vld_errs), 64'h0);
        check("drop_sat", 64'(drop_cnt), 64'd255);

        // Fill columns 0,1,3 then reset asynchronously between edges.
        out_ready = 4'b0000;
        in_valid = 1'b1; in_tag = 4'd5; in_data = 16'h7777;
        tick();
        in_tag = 4'd1; in_data = 16'h8888;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'b1011);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'h0);
        check("async_rst_drop",  64'(drop_cnt), 64'h0);
        check("async_rst_data",  out_data, 64'h0);
        tick();
        rst = 1'b0;
        out_ready = 4'hF;
        for (int t = 0; t < NC; t++) begin
            in_valid = 1'b1; in_tag = IW'(t); in_data = 16'h0100 + 16'(t);
            tick();
            check($sformatf("rst_id%0d_valid", t), 64'(out_valid), 64'(1 << t));
            check($sformatf("rst_id%0d_data", t), 64'(col_data(t)), 64'h0100 + 64'(t));
        end
        in_valid = 1'b0;
        tick();

        // Same-edge config write and accept: the word matches the old ID.
        cfg_we = 1'b1; cfg_col = 2'd1; cfg_id = 4'd7;
        in_valid = 1'b1; in_tag = 4'd1; in_data = 16'h3333;
        tick();
        cfg_we = 1'b0;
        check("race_valid", 64'(out_valid), 64'b0010);
        check("race_data1", 64'(col_data(1)), 64'h3333);
        check("race_drop",  64'(drop_cnt), 64'h0);
        in_data = 16'h4444;
        tick();
        check("race_old_valid", 64'(out_valid), 64'h0);
        check("race_old_drop",  64'(drop_cnt), 64'h1);
        in_tag = 4'd7; in_data = 16'h5555;
        tick();
        in_valid = 1'b0;
        check("race_new_valid", 64'(out_valid), 64'b0010);
        check("race_new_data1", 64'(col_data(1)), 64'h5555);
        tick();

        // Back-to-back words to column 0.
        rdy_errs = 0;
        in_valid = 1'b1; in_tag = 4'd0;
        for (int i = 0; i < 16; i++) begin
            in_data = 16'(i);
            #1;
            if (in_ready !== 1'b1) rdy_errs++;
            tick();
            check($sformatf("b2b_valid%0d", i), 64'(out_valid), 64'b0001);
            check($sformatf("b2b_data%0d", i), 64'(col_data(0)), 64'(i));
        end
        in_valid = 1'b0;
        check("b2b_rdy_errs", 64'(rdy_errs), 64'h0);
        tick();

        // All-ones tag: broadcast when enabled, otherwise an ordinary unmatched tag.
        in_valid = 1'b1; in_tag = 4'hF; in_data = 16'h5A5A;
        tick();
        in_valid = 1'b0;
`ifdef MULTICAST_ROUTER_BCAST_EN
        check("bcast_valid", 64'(out_valid), 64'hF);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("bcast_data%0d", i), 64'(col_data(i)), 64'h5A5A);
        end
        check("bcast_drop", 64'(drop_cnt), 64'h1);
`else
        check("allones_valid", 64'(out_valid), 64'h0);
        check("allones_drop",  64'(drop_cnt), 64'h2);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
